// File: rtl/othello_pkg.sv
// Shared Othello definitions: side codes, direction deltas, screen geometry
// and the disk_flipper state encoding.
package othello_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } side_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_NEXT_DIR = 3'd1,
        S_STEP     = 3'd2,
        S_READ     = 3'd3,
        S_CHECK    = 3'd4,
        S_WRITE    = 3'd5,
        S_PLOT     = 3'd6,
        S_FINISH   = 3'd7
    } flip_state_t;

    localparam int DEF_CELL_PX = 14;
    localparam int DEF_X0      = 24;
    localparam int DEF_Y0      = 4;

    // Deltas are 4-bit two's complement; y grows downward (0=N, clockwise to 7=NW).
    function automatic logic [3:0] dir_dx(input logic [2:0] k);
        case (k)
            3'd1, 3'd2, 3'd3: dir_dx = 4'sd1;
            3'd5, 3'd6, 3'd7: dir_dx = -4'sd1;
            default:          dir_dx = 4'sd0;
        endcase
    endfunction

    function automatic logic [3:0] dir_dy(input logic [2:0] k);
        case (k)
            3'd7, 3'd0, 3'd1: dir_dy = -4'sd1;
            3'd3, 3'd4, 3'd5: dir_dy = 4'sd1;
            default:          dir_dy = 4'sd0;
        endcase
    endfunction

    function automatic logic [2:0] lowest_dir(input logic [7:0] m);
        lowest_dir = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_dir = 3'(i);
        end
    endfunction

endpackage

// File: rtl/disk_flipper_dir_step.sv
// Combinational cursor advance: one step along direction k, with a flag set
// when the new cell falls off the 8x8 board.
module dir_step
    import othello_pkg::*;
(
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic [2:0] k,
    output logic [2:0] nx,
    output logic [2:0] ny,
    output logic       oob
);

    logic [3:0] sum_x;
    logic [3:0] sum_y;

    // Inputs are 0..7 and deltas -1..+1, so bit 3 set means -1 or 8.
    always_comb begin
        sum_x = {1'b0, x} + dir_dx(k);
        sum_y = {1'b0, y} + dir_dy(k);
    end

    assign nx  = sum_x[2:0];
    assign ny  = sum_y[2:0];
    assign oob = sum_x[3] | sum_y[3];

endmodule

// File: rtl/disk_flipper.sv
// Walks each legal direction from a placed disk, rewrites captured opponent
// disks in board RAM and requests one cell redraw per flip.
module disk_flipper
    import othello_pkg::*;
#(
    parameter int CELL_PX = DEF_CELL_PX,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] x_in,
    input  logic [2:0] y_in,
    input  logic [1:0] side,
    input  logic [7:0] dir,
    output logic [2:0] rd_x,
    output logic [2:0] rd_y,
    input  logic [1:0] rd_q,
    output logic       wr_en,
    output logic [2:0] wr_x,
    output logic [2:0] wr_y,
    output logic [1:0] wr_data,
    output logic       plot_req,
    output logic [7:0] x_plot,
    output logic [6:0] y_plot,
    output logic [1:0] select,
    input  logic       plot_done,
    output logic       busy,
    output logic       done,
    output logic [4:0] flips,
    output logic [2:0] state
);

    flip_state_t st;
    logic [2:0]  org_x, org_y;
    logic [2:0]  cur_x, cur_y;
    logic [2:0]  dir_k;
    logic [1:0]  mover;
    logic [7:0]  mask;
    logic [2:0]  step_x, step_y;
    logic        step_oob;
    logic [1:0]  opponent;

    assign opponent = {mover[0], mover[1]};
    assign state    = st;

    dir_step u_dir_step (
        .x   (cur_x),
        .y   (cur_y),
        .k   (dir_k),
        .nx  (step_x),
        .ny  (step_y),
        .oob (step_oob)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st       <= S_IDLE;
            org_x    <= '0;
            org_y    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            dir_k    <= '0;
            mover    <= '0;
            mask     <= '0;
            rd_x     <= '0;
            rd_y     <= '0;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
            plot_req <= 1'b0;
            x_plot   <= '0;
            y_plot   <= '0;
            select   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            flips    <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        org_x <= x_in;
                        org_y <= y_in;
                        mover <= side;
                        mask  <= dir;
                        flips <= '0;
                        busy  <= 1'b1;
                        st    <= S_NEXT_DIR;
                    end
                end
                S_NEXT_DIR: begin
                    if (mask == 8'd0) begin
                        done <= 1'b1;
                        st   <= S_FINISH;
                    end else begin
                        dir_k <= lowest_dir(mask);
                        mask  <= mask & (mask - 8'd1);
                        cur_x <= org_x;
                        cur_y <= org_y;
                        st    <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (step_oob) begin
                        st <= S_NEXT_DIR;
                    end else begin
                        cur_x <= step_x;
                        cur_y <= step_y;
                        rd_x  <= step_x;
                        rd_y  <= step_y;
                        st    <= S_READ;
                    end
                end
                S_READ: st <= S_CHECK;
                S_CHECK: begin
                    // Own colour or empty ends the run; only opponents are captured.
                    if (rd_q == opponent) begin
                        wr_en   <= 1'b1;
                        wr_x    <= cur_x;
                        wr_y    <= cur_y;
                        wr_data <= mover;
                        st      <= S_WRITE;
                    end else begin
                        st <= S_NEXT_DIR;
                    end
                end
                S_WRITE: begin
                    flips    <= flips + 5'd1;
                    plot_req <= 1'b1;
                    x_plot   <= 8'(X0 + CELL_PX * int'(cur_x));
                    y_plot   <= 7'(Y0 + CELL_PX * int'(cur_y));
                    select   <= mover;
                    st       <= S_PLOT;
                end
                S_PLOT: begin
                    if (plot_done) begin
                        plot_req <= 1'b0;
                        st       <= S_STEP;
                    end
                end
                S_FINISH: begin
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disk_flipper.sv
// Directed and randomized checks of disk_flipper against a board-walk
// reference model, a board RAM model and a plothelper responder.
module tb_disk_flipper;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] x_in = '0, y_in = '0;
    logic [1:0] side = '0;
    logic [7:0] dir = '0;
    logic [2:0] rd_x, rd_y;
    logic [1:0] rd_q = '0;
    logic       wr_en;
    logic [2:0] wr_x, wr_y;
    logic [1:0] wr_data;
    logic       plot_req;
    logic [7:0] x_plot;
    logic [6:0] y_plot;
    logic [1:0] select;
    logic       plot_done;
    logic       busy, done;
    logic [4:0] flips;
    logic [2:0] dut_state;

    int checks = 0;
    int failures = 0;

    logic [1:0] board [0:7][0:7];
    logic [1:0] setup [0:7][0:7];
    logic       load_board = 1'b0;
    int         plot_wait = 0;
    int         plot_cnt = 0;
    logic       plot_hold_high = 1'b0;
    logic       plot_done_r = 1'b0;
    logic       plot_req_d = 1'b0;
    logic [7:0]  wr_log[$];
    logic [16:0] plot_log[$];

    int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    disk_flipper dut (
        .clock(clock), .resetn(resetn), .start(start),
        .x_in(x_in), .y_in(y_in), .side(side), .dir(dir),
        .rd_x(rd_x), .rd_y(rd_y), .rd_q(rd_q),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .plot_req(plot_req), .x_plot(x_plot), .y_plot(y_plot), .select(select),
        .plot_done(plot_done), .busy(busy), .done(done), .flips(flips),
        .state(dut_state)
    );

    always #5 clock = ~clock;

    // Board RAM: registered read, write on strobe, bulk load for test setup.
    always @(posedge clock) begin
        rd_q <= board[rd_y][rd_x];
        if (load_board) board <= setup;
        else if (wr_en) board[wr_y][wr_x] <= wr_data;
    end

    // plothelper stand-in: answers plot_wait cycles after a request.
    always @(posedge clock) begin
        if (plot_req && !plot_done_r) begin
            if (plot_cnt >= plot_wait) plot_done_r <= 1'b1;
            else plot_cnt <= plot_cnt + 1;
        end else begin
            plot_done_r <= 1'b0;
            plot_cnt <= 0;
        end
    end
    assign plot_done = plot_done_r | plot_hold_high;

    always @(negedge clock) begin
        if (wr_en) wr_log.push_back({wr_y, wr_x, wr_data});
        if (plot_req && !plot_req_d) plot_log.push_back({x_plot, y_plot, select});
        plot_req_d <= plot_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, plot_req, x_plot, y_plot,
                select, busy, done, flips, dut_state};
    endfunction

    task automatic clear_setup();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) setup[r][c] = 2'b00;
    endtask

    task automatic load();
        @(posedge clock); #1 load_board = 1'b1;
        @(posedge clock); #1 load_board = 1'b0;
    endtask

    task automatic opening_board();
        clear_setup();
        setup[3][3] = 2'b10; setup[4][4] = 2'b10;
        setup[3][4] = 2'b01; setup[4][3] = 2'b01;
        load();
    endtask

    task automatic pulse_start(input logic [2:0] ox, oy, input logic [1:0] sd, input logic [7:0] dm);
        @(posedge clock); #1;
        x_in = ox; y_in = oy; side = sd; dir = dm; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clock); #1 n++;
        end
        chk({tag, " done"}, done, 1'b1);
    endtask

    task automatic run_move(input string tag, input logic [2:0] ox, oy,
                            input logic [1:0] sd, input logic [7:0] dm);
        logic [1:0]  brd [0:7][0:7];
        logic [7:0]  exp_w[$];
        logic [16:0] exp_p[$];
        logic [1:0]  opp;
        int cx, cy, cost, n, bad;
        brd = board;
        opp = {sd[0], sd[1]};
        cost = 1;
        for (int k = 0; k < 8; k++) begin
            if (dm[k]) begin
                cost += 1;
                cx = ox; cy = oy;
                while (1) begin
                    cx += dxs[k]; cy += dys[k];
                    if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
                        cost += 1;
                        break;
                    end
                    if (brd[cy][cx] != opp) begin
                        cost += 3;
                        break;
                    end
                    brd[cy][cx] = sd;
                    exp_w.push_back({3'(cy), 3'(cx), sd});
                    exp_p.push_back({8'(24 + 14 * cx), 7'(4 + 14 * cy), sd});
                    cost += 5;
                end
            end
        end
        wr_log.delete();
        plot_log.delete();
        pulse_start(ox, oy, sd, dm);
        chk({tag, " busy"}, busy, 1'b1);
        wait_done(tag, n);
        if (plot_hold_high) chk({tag, " latency"}, n, cost);
        chk({tag, " flips"}, flips, exp_w.size());
        chk({tag, " writes"}, wr_log.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            chk($sformatf("%s write%0d", tag, i), (i < wr_log.size()) ? wr_log[i] : 8'hxx, exp_w[i]);
        chk({tag, " plots"}, plot_log.size(), exp_p.size());
        for (int i = 0; i < exp_p.size(); i++)
            chk($sformatf("%s plot%0d", tag, i), (i < plot_log.size()) ? plot_log[i] : 17'hx, exp_p[i]);
        @(posedge clock); #1;
        bad = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (board[r][c] !== brd[r][c]) bad++;
        chk({tag, " board"}, bad, 0);
        chk({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        int n, changes;
        logic [7:0] px;
        logic [6:0] py;
        logic [1:0] ps;
        logic [2:0] rx, ry;

        clear_setup();
        board = setup;
        repeat (3) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        repeat (3) @(posedge clock);

        // Reset asserted mid-idle.
        #3 resetn = 1'b0;
        #1 chk("reset outputs", all_outputs(), 64'd0);
        @(negedge clock) resetn = 1'b1;

        // Empty mask: done two cycles after start.
        pulse_start(3'd0, 3'd0, 2'b01, 8'h00);
        chk("dir0 busy", {busy, done}, 2'b10);
        @(posedge clock); #1 chk("dir0 done", {busy, done}, 2'b11);
        @(posedge clock); #1 chk("dir0 after", {busy, done, flips}, 7'd0);

        // Opening move, plot accepted on entry.
        plot_hold_high = 1'b1;
        opening_board();
        run_move("opening", 3'd2, 3'd3, 2'b01, 8'h04);

        // Two opponents then own disk along E and S.
        clear_setup();
        setup[1][2] = 2'b10; setup[1][3] = 2'b10; setup[1][4] = 2'b01;
        setup[2][1] = 2'b10; setup[3][1] = 2'b10; setup[4][1] = 2'b01;
        load();
        run_move("multi", 3'd1, 3'd1, 2'b01, 8'h14);
        chk("multi flips4", flips, 5'd4);
        repeat (2) @(posedge clock);
        #1 chk("flips hold", flips, 5'd4);

        // Corner origin whose only direction leaves the board.
        opening_board();
        run_move("corner", 3'd7, 3'd0, 2'b10, 8'h02);

        // Plot stall with a start pulse that must be ignored.
        plot_hold_high = 1'b0;
        plot_wait = 20;
        opening_board();
        wr_log.delete();
        pulse_start(3'd2, 3'd3, 2'b01, 8'h04);
        n = 0;
        while (!plot_req && n < 100) begin
            @(posedge clock); #1 n++;
        end
        chk("stall plot_req", plot_req, 1'b1);
        px = x_plot; py = y_plot; ps = select; rx = rd_x; ry = rd_y;
        chk("stall coords", {px, py, ps}, {8'd66, 7'd46, 2'b01});
        changes = 0;
        x_in = 3'd0; y_in = 3'd0; side = 2'b10; dir = 8'hff; start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (i == 2) start = 1'b0;
            if (!plot_req || wr_en || x_plot !== px || y_plot !== py || select !== ps ||
                rd_x !== rx || rd_y !== ry) changes++;
        end
        start = 1'b0;
        chk("stall stable", changes, 0);
        wait_done("stall", n);
        chk("stall flips", flips, 5'd1);
        chk("stall writes", wr_log.size(), 1);
        repeat (3) @(posedge clock);
        #1 chk("stall no restart", busy, 1'b0);

        // Reset while waiting in PLOT, then a clean opening move.
        opening_board();
        pulse_start(3'd2, 3'd3, 2'b01, 8'h04);
        n = 0;
        while (!plot_req && n < 100) begin
            @(posedge clock); #1 n++;
        end
        chk("rst plot_req", plot_req, 1'b1);
        #2 resetn = 1'b0;
        #1 chk("rst in plot", all_outputs(), 64'd0);
        @(negedge clock) resetn = 1'b1;
        plot_wait = 0;
        opening_board();
        run_move("post reset", 3'd2, 3'd3, 2'b01, 8'h04);

        // Random boards, origins, masks and plot handshakes.
        for (int t = 0; t < 25; t++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) setup[r][c] = 2'($urandom_range(0, 2));
            load();
            plot_wait = $urandom_range(0, 3);
            plot_hold_high = 1'($urandom_range(0, 1));
            run_move($sformatf("rand%0d", t), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     2'($urandom_range(1, 2)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
